// File: rtl/irq_pkg.sv
// irq_pkg: shared constants and helpers for the interrupt controller.
//   N_IRQ_DEF - default number of request lines
//   NO_ISR    - "no line" value for a signed top-index (empty in-service set)
//   id_width  - width of a line ID for a given line count
package irq_pkg;

  localparam int unsigned N_IRQ_DEF = 3;
  localparam int          NO_ISR    = -1;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_if.sv
// irq_if: request lines and CPU handshake of the interrupt controller.
//   irq_raw    - raw asynchronous request lines (active-high)
//   irq_mask   - 1 = line masked
//   int_req    - interrupt request to the CPU
//   int_id     - ID of the requested line, valid while int_req = 1
//   int_ack    - CPU enters handler for int_id (one-cycle pulse)
//   int_eoi    - CPU leaves the current handler (one-cycle pulse)
//   in_service - lines currently being serviced
//   irw        - pending bits, to LEDs
// modport master: the controller side; modport slave: the CPU/board side.
interface irq_if #(
  parameter int unsigned N_IRQ = irq_pkg::N_IRQ_DEF
) ();
  localparam int unsigned IdW = irq_pkg::id_width(N_IRQ);

  logic [N_IRQ-1:0] irq_raw;
  logic [N_IRQ-1:0] irq_mask;
  logic             int_req;
  logic [IdW-1:0]   int_id;
  logic             int_ack;
  logic             int_eoi;
  logic [N_IRQ-1:0] in_service;
  logic [N_IRQ-1:0] irw;

  modport master (
    input  irq_raw, irq_mask, int_ack, int_eoi,
    output int_req, int_id, in_service, irw
  );

  modport slave (
    output irq_raw, irq_mask, int_ack, int_eoi,
    input  int_req, int_id, in_service, irw
  );
endinterface

// File: rtl/irq_conditioner.sv
// irq_conditioner: conditions one raw request line.
//   clk    - block clock
//   rst    - synchronous reset, active-low
//   raw_i  - asynchronous raw request line
//   rise_o - one-cycle pulse on a debounced rising edge
// 2-FF synchronizer, then a debounce filter: the filtered level follows the
// synchronized level only after DEBOUNCE consecutive differing samples.
module irq_conditioner #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic rise_o
);
  localparam logic [7:0] CntLast = 8'(DEBOUNCE - 1);

  logic       sync1_q, sync2_q;
  logic [1:0] prime_q;
  logic [7:0] cnt_q, cnt_d;
  logic       filt_q, filt_d;
  logic       filt_dly_q;
  logic       arm_q, arm_d;

  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (sync2_q == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      filt_d = sync2_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
    // Edges are only reported once the line has been seen low after reset,
    // so a line held high across reset does not replay a request.
    arm_d = arm_q | (prime_q[1] & ~sync2_q & ~filt_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prime_q    <= '0;
      cnt_q      <= '0;
      filt_q     <= 1'b0;
      filt_dly_q <= 1'b0;
      arm_q      <= 1'b0;
    end else begin
      sync1_q    <= raw_i;
      sync2_q    <= sync1_q;
      prime_q    <= {prime_q[0], 1'b1};  // prime_q[1]: sync2_q holds a real sample
      cnt_q      <= cnt_d;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      arm_q      <= arm_d;
    end
  end

  assign rise_o = arm_q & filt_q & ~filt_dly_q;

endmodule

// File: rtl/irq_controller.sv
// irq_controller: conditions N_IRQ request lines, latches pending requests,
// resolves fixed priority (higher index wins) with nesting against the
// in-service set, and drives one request/ID to the CPU via ack/EOI.
//   clk - block clock (CPU clock)
//   rst - synchronous reset, active-low
//   bus - irq_if.master: irq_raw, irq_mask, int_ack, int_eoi in;
//         int_req, int_id, in_service, irw out (all outputs registered)
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned N_IRQ    = N_IRQ_DEF,
  parameter int unsigned DEBOUNCE = 4
) (
  input logic   clk,
  input logic   rst,
  irq_if.master bus
);
  localparam int unsigned IdW = id_width(N_IRQ);

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [N_IRQ-1:0] isr_q, isr_d;
  logic [N_IRQ-1:0] ack_oh, eoi_oh, eligible;
  logic             ack_ok;
  logic             int_req_q, int_req_d;
  logic [IdW-1:0]   int_id_q, int_id_d;
  int               top_pend, top_isr;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_cond
    irq_conditioner #(
      .DEBOUNCE(DEBOUNCE)
    ) u_cond (
      .clk   (clk),
      .rst   (rst),
      .raw_i (bus.irq_raw[g]),
      .rise_o(rise[g])
    );
  end

  always_comb begin
    ack_ok = bus.int_ack & int_req_q;
    ack_oh = '0;
    eoi_oh = '0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (int_id_q == IdW'(i)) ack_oh[i] = ack_ok;
      // Later (higher) set bits override, leaving only the highest one.
      if (isr_q[i]) begin
        eoi_oh    = '0;
        eoi_oh[i] = bus.int_eoi;
      end
    end

    // A rise in the same cycle as the ack keeps the line pending.
    pend_d = (pend_q & ~ack_oh) | rise;
    // EOI acts on the pre-ack in-service set, then the ack is applied.
    isr_d  = (isr_q & ~eoi_oh) | ack_oh;

    // Request is computed on next-state values so it appears one cycle
    // after the causing event, together with the updated pend/in_service.
    eligible = pend_d & ~bus.irq_mask;
    top_pend = NO_ISR;
    top_isr  = NO_ISR;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (eligible[i]) top_pend = int'(i);
      if (isr_d[i])    top_isr  = int'(i);
    end
    int_req_d = (top_pend != NO_ISR) && (top_pend > top_isr);
    int_id_d  = (top_pend == NO_ISR) ? '0 : IdW'(top_pend);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q    <= '0;
      isr_q     <= '0;
      int_req_q <= 1'b0;
      int_id_q  <= '0;
    end else begin
      pend_q    <= pend_d;
      isr_q     <= isr_d;
      int_req_q <= int_req_d;
      int_id_q  <= int_id_d;
    end
  end

  assign bus.int_req    = int_req_q;
  assign bus.int_id     = int_id_q;
  assign bus.in_service = isr_q;
  assign bus.irw        = pend_q;

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: self-checking bench for irq_controller (N_IRQ=3,
// DEBOUNCE=4). Expected outputs are queued when stimulus is driven and
// compared when the outputs are sampled (1 time unit after the clock edge).
module tb_irq_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  irq_if #(.N_IRQ(3)) bus ();

  irq_controller #(
    .N_IRQ   (3),
    .DEBOUNCE(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string       name;
    logic        req;
    logic [1:0]  id;
    logic [2:0]  isr;
    logic [2:0]  irw;
  } exp_t;

  typedef struct {
    string       name;
    logic        rst_n;
    logic [2:0]  raw;
    logic [2:0]  mask;
    logic        ack;
    logic        eoi;
    int unsigned hold;
    logic        req;
    logic [1:0]  id;
    logic [2:0]  isr;
    logic [2:0]  irw;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input string n, input logic req, input logic [1:0] id,
                          input logic [2:0] isr, input logic [2:0] irw);
    exp_t e;
    e.name = n; e.req = req; e.id = id; e.isr = isr; e.irw = irw;
    sb.push_back(e);
  endtask

  task automatic check_head();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_underflow: no expected entry at time %0t", $time);
    end else begin
      e = sb.pop_front();
      if (bus.int_req !== e.req || bus.int_id !== e.id ||
          bus.in_service !== e.isr || bus.irw !== e.irw) begin
        errors++;
        $display("FAIL %s: got req=%b id=%0d isr=%b irw=%b, want req=%b id=%0d isr=%b irw=%b",
                 e.name, bus.int_req, bus.int_id, bus.in_service, bus.irw,
                 e.req, e.id, e.isr, e.irw);
      end
    end
  endtask

  task automatic expect_now(input string n, input logic req, input logic [1:0] id,
                            input logic [2:0] isr, input logic [2:0] irw);
    push_exp(n, req, id, isr, irw);
    check_head();
  endtask

  task automatic pulse(input logic ack, input logic eoi);
    bus.int_ack = ack;
    bus.int_eoi = eoi;
    tick(1);
    bus.int_ack = 1'b0;
    bus.int_eoi = 1'b0;
  endtask

  task automatic add_vec(input string n, input logic r, input logic [2:0] raw,
                         input logic [2:0] mask, input logic ack, input logic eoi,
                         input int unsigned hold, input logic req, input logic [1:0] id,
                         input logic [2:0] isr, input logic [2:0] irw);
    vec_t v;
    v.name = n; v.rst_n = r; v.raw = raw; v.mask = mask; v.ack = ack; v.eoi = eoi;
    v.hold = hold; v.req = req; v.id = id; v.isr = isr; v.irw = irw;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    rst          = v.rst_n;
    bus.irq_raw  = v.raw;
    bus.irq_mask = v.mask;
    bus.int_ack  = v.ack;
    bus.int_eoi  = v.eoi;
    push_exp(v.name, v.req, v.id, v.isr, v.irw);
    tick(1);
    bus.int_ack = 1'b0;
    bus.int_eoi = 1'b0;
    rst         = 1'b1;
    if (v.hold > 1) tick(v.hold - 1);
    check_head();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //      name        rst raw     mask    ack eoi hold req id isr     irw
    add_vec("p02",      1, 3'b101, 3'b000, 0, 0, 10, 1, 2, 3'b000, 3'b101);
    add_vec("ack2",     1, 3'b101, 3'b000, 1, 0, 1,  0, 0, 3'b100, 3'b001);
    add_vec("eoi2",     1, 3'b101, 3'b000, 0, 1, 1,  1, 0, 3'b000, 3'b001);
    add_vec("ack0",     1, 3'b101, 3'b000, 1, 0, 1,  0, 0, 3'b001, 3'b000);
    add_vec("drop",     1, 3'b000, 3'b000, 0, 0, 10, 0, 0, 3'b001, 3'b000);
    add_vec("nest2",    1, 3'b100, 3'b000, 0, 0, 10, 1, 2, 3'b001, 3'b100);
    add_vec("ack_nest", 1, 3'b100, 3'b000, 1, 0, 1,  0, 0, 3'b101, 3'b000);
    add_vec("eoi_nest", 1, 3'b100, 3'b000, 0, 1, 1,  0, 0, 3'b001, 3'b000);
    add_vec("drop2",    1, 3'b000, 3'b000, 0, 0, 10, 0, 0, 3'b001, 3'b000);
    add_vec("p1_nest",  1, 3'b010, 3'b000, 0, 0, 10, 1, 1, 3'b001, 3'b010);
    add_vec("ack1",     1, 3'b010, 3'b000, 1, 0, 1,  0, 0, 3'b011, 3'b000);
    add_vec("eoi1",     1, 3'b010, 3'b000, 0, 1, 1,  0, 0, 3'b001, 3'b000);
    add_vec("eoi0",     1, 3'b010, 3'b000, 0, 1, 1,  0, 0, 3'b000, 3'b000);
    add_vec("eoi_empty",1, 3'b010, 3'b000, 0, 1, 1,  0, 0, 3'b000, 3'b000);
    add_vec("ack_noreq",1, 3'b010, 3'b000, 1, 0, 1,  0, 0, 3'b000, 3'b000);
    add_vec("drop1",    1, 3'b000, 3'b000, 0, 0, 10, 0, 0, 3'b000, 3'b000);
    add_vec("mask2",    1, 3'b100, 3'b100, 0, 0, 10, 0, 0, 3'b000, 3'b100);
    add_vec("unmask2",  1, 3'b100, 3'b000, 0, 0, 1,  1, 2, 3'b000, 3'b100);
    add_vec("rst_mid",  0, 3'b100, 3'b000, 0, 0, 1,  0, 0, 3'b000, 3'b000);
    add_vec("no_replay",1, 3'b100, 3'b000, 0, 0, 12, 0, 0, 3'b000, 3'b000);
    add_vec("drop3",    1, 3'b000, 3'b000, 0, 0, 10, 0, 0, 3'b000, 3'b000);
    add_vec("p0",       1, 3'b001, 3'b000, 0, 0, 10, 1, 0, 3'b000, 3'b001);
    add_vec("ack0b",    1, 3'b001, 3'b000, 1, 0, 1,  0, 0, 3'b001, 3'b000);
    add_vec("p2b",      1, 3'b101, 3'b000, 0, 0, 10, 1, 2, 3'b001, 3'b100);
    add_vec("ack_eoi",  1, 3'b101, 3'b000, 1, 1, 1,  0, 0, 3'b100, 3'b000);
    add_vec("eoi_end",  1, 3'b101, 3'b000, 0, 1, 1,  0, 0, 3'b000, 3'b000);

    // Reset held with all raw lines high: outputs stay zero throughout.
    rst          = 1'b0;
    bus.irq_raw  = 3'b111;
    bus.irq_mask = 3'b000;
    bus.int_ack  = 1'b0;
    bus.int_eoi  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      expect_now("reset_hold", 0, 0, 3'b000, 3'b000);
    end
    rst = 1'b1;
    tick(15);
    expect_now("held_high_no_rise", 0, 0, 3'b000, 3'b000);
    bus.irq_raw = 3'b000;
    tick(10);

    // 3-cycle glitch on line 0 is filtered out.
    bus.irq_raw = 3'b001;
    tick(3);
    bus.irq_raw = 3'b000;
    tick(10);
    expect_now("glitch0", 0, 0, 3'b000, 3'b000);

    // Line 1 rise: pending and requested exactly 7 cycles after the change.
    bus.irq_raw = 3'b010;
    tick(6);
    expect_now("lat_minus1", 0, 0, 3'b000, 3'b000);
    tick(1);
    expect_now("lat_exact", 1, 1, 3'b000, 3'b010);

    // New rise on line 1 in the same cycle as its ack: set wins.
    bus.irq_raw = 3'b000;
    tick(10);
    expect_now("still_pend1", 1, 1, 3'b000, 3'b010);
    bus.irq_raw = 3'b010;
    tick(6);
    expect_now("pre_sim", 1, 1, 3'b000, 3'b010);
    pulse(1'b1, 1'b0);
    expect_now("sim_ack_rise", 0, 1, 3'b010, 3'b010);
    tick(3);
    expect_now("sim_wait", 0, 1, 3'b010, 3'b010);
    pulse(1'b0, 1'b1);
    expect_now("sim_eoi", 1, 1, 3'b000, 3'b010);
    pulse(1'b1, 1'b0);
    expect_now("sim_ack2", 0, 0, 3'b010, 3'b000);
    pulse(1'b0, 1'b1);
    expect_now("sim_eoi2", 0, 0, 3'b000, 3'b000);
    bus.irq_raw = 3'b000;
    tick(10);

    foreach (vecs[k]) apply(vecs[k]);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
